// File: rtl/fdiv_seq.sv
// Control stage in front of the combinational single-precision divider: handshakes a request,
// holds operands for a multicycle window, then resolves IEEE special cases and exponent range.
module fdiv_seq #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] s,
    input  logic [31:0] t,
    output logic [31:0] div_s,
    output logic [31:0] div_t,
    input  logic [31:0] div_d,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] d,
    output logic        divzero,
    output logic        invalid,
    output logic        overflow,
    output logic        underflow
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    function automatic logic is_zero(input logic [31:0] x);
        return (x[30:23] == 8'd0);
    endfunction

    function automatic logic is_inf(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    endfunction

    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    state_t             state;
    logic [3:0]         cnt;
    logic               special_r;
    logic               sign_r;
    logic signed [9:0]  e_r;

    logic               sign_s;
    logic               s_zero_s;
    logic               t_zero_s;
    logic               s_inf_s;
    logic               t_inf_s;
    logic               any_nan_s;
    logic               special_s;
    logic [31:0]        spec_d_s;
    logic               spec_inv_s;
    logic               spec_dz_s;
    logic signed [9:0]  e_s;

    // Operand classification, special-case result and biased quotient exponent estimate
    always_comb begin
        sign_s     = s[31] ^ t[31];
        s_zero_s   = is_zero(s);
        t_zero_s   = is_zero(t);
        s_inf_s    = is_inf(s);
        t_inf_s    = is_inf(t);
        any_nan_s  = is_nan(s) || is_nan(t);
        special_s  = any_nan_s || s_zero_s || t_zero_s || s_inf_s || t_inf_s;
        spec_d_s   = 32'd0;
        spec_inv_s = 1'b0;
        spec_dz_s  = 1'b0;
        if (any_nan_s || (s_zero_s && t_zero_s) || (s_inf_s && t_inf_s)) begin
            spec_d_s   = 32'h7FC0_0000;
            spec_inv_s = 1'b1;
        end else if (t_zero_s) begin
            spec_d_s  = {sign_s, 8'hFF, 23'd0};
            spec_dz_s = 1'b1;
        end else if (s_inf_s) begin
            spec_d_s = {sign_s, 8'hFF, 23'd0};
        end else if (t_inf_s || s_zero_s) begin
            spec_d_s = {sign_s, 31'd0};
        end else begin
            spec_d_s = 32'd0;
        end
        // a smaller dividend fraction costs one exponent step after normalisation
        e_s = $signed({2'b00, s[30:23]}) - $signed({2'b00, t[30:23]}) + 10'sd127
              - ((s[22:0] < t[22:0]) ? 10'sd1 : 10'sd0);
    end

    // Handshake FSM with registered outputs; operands stay on div_s/div_t until the next accept
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= 4'd0;
            special_r  <= 1'b0;
            sign_r     <= 1'b0;
            e_r        <= 10'sd0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            d          <= 32'd0;
            divzero    <= 1'b0;
            invalid    <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            div_s      <= 32'd0;
            div_t      <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        div_s     <= s;
                        div_t     <= t;
                        sign_r    <= sign_s;
                        e_r       <= e_s;
                        req_ready <= 1'b0;
                        state     <= ST_WAIT;
                        if (special_s) begin
                            special_r <= 1'b1;
                            cnt       <= 4'd0;
                            d         <= spec_d_s;
                            invalid   <= spec_inv_s;
                            divzero   <= spec_dz_s;
                            overflow  <= 1'b0;
                            underflow <= 1'b0;
                        end else begin
                            special_r <= 1'b0;
                            cnt       <= CNT_INIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        resp_valid <= 1'b1;
                        state      <= ST_DONE;
                        if (!special_r) begin
                            invalid <= 1'b0;
                            divzero <= 1'b0;
                            if (e_r >= 10'sd255) begin
                                d         <= {sign_r, 8'hFF, 23'd0};
                                overflow  <= 1'b1;
                                underflow <= 1'b0;
                            end else if (e_r <= 10'sd0) begin
                                d         <= {sign_r, 31'd0};
                                overflow  <= 1'b0;
                                underflow <= 1'b1;
                            end else begin
                                d         <= div_d;
                                overflow  <= 1'b0;
                                underflow <= 1'b0;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fdiv_seq.sv
// Directed bench for fdiv_seq with a lookup-table stand-in for the combinational divider
// and a scoreboard queue of expected results, latencies and flags.
module tb_fdiv_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] s;
    logic [31:0] t;
    logic [31:0] div_s;
    logic [31:0] div_t;
    logic [31:0] div_d;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] d;
    logic        divzero;
    logic        invalid;
    logic        overflow;
    logic        underflow;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] d;
        logic [3:0]  fl;
        logic [3:0]  lat;
    } exp_t;

    exp_t q[$];

    fdiv_seq #(.WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .s(s), .t(t), .div_s(div_s), .div_t(div_t), .div_d(div_d),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .d(d),
        .divzero(divzero), .invalid(invalid), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // Quotients for the normal-range vectors; anything else returns a marker the DUT must override.
    function automatic logic [31:0] fdiv_model(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            64'h40C00000_40000000: return 32'h40400000;
            64'hBF800000_40800000: return 32'hBE800000;
            64'h3F800000_40400000: return 32'h3EAAAAAB;
            default:               return 32'h5A5A5A5A;
        endcase
    endfunction

    always_comb div_d = fdiv_model(div_s, div_t);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] ed,
                         input logic [3:0] efl, input logic [3:0] elat);
        @(negedge clk);
        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        s = a;
        t = b;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        q.push_back('{a: a, b: b, d: ed, fl: efl, lat: elat});
    endtask

    task automatic collect(input string tag);
        exp_t e;
        int   lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!resp_valid && lat < 20);
        e = q.pop_front();
        chk({tag, "_valid"}, {31'd0, resp_valid}, 32'd1);
        chk({tag, "_lat"}, 32'(lat), {28'd0, e.lat});
        chk({tag, "_d"}, d, e.d);
        chk({tag, "_flags"}, {28'd0, invalid, divzero, overflow, underflow}, {28'd0, e.fl});
        chk({tag, "_busy"}, {31'd0, req_ready}, 32'd0);
        chk({tag, "_div_s"}, div_s, e.a);
        chk({tag, "_div_t"}, div_t, e.b);
    endtask

    task automatic finish_hs(input string tag);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_hs_valid"}, {31'd0, resp_valid}, 32'd0);
        chk({tag, "_hs_ready"}, {31'd0, req_ready}, 32'd1);
    endtask

    task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ed, input logic [3:0] efl, input logic [3:0] elat);
        issue(a, b, ed, efl, elat);
        collect(tag);
        finish_hs(tag);
    endtask

    initial begin
        logic seen;
        rst        = 1'b1;
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        s          = 32'd0;
        t          = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_d", d, 32'd0);
        chk("rst_flags", {28'd0, invalid, divzero, overflow, underflow}, 32'd0);
        chk("rst_div_s", div_s, 32'd0);
        chk("rst_div_t", div_t, 32'd0);
        rst = 1'b0;

        // flags nibble is {invalid, divzero, overflow, underflow}
        run("six_by_two",  32'h40C00000, 32'h40000000, 32'h40400000, 4'h0, 4'd2);
        run("neg_quarter", 32'hBF800000, 32'h40800000, 32'hBE800000, 4'h0, 4'd2);
        run("one_third",   32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'h0, 4'd2);
        run("div_by_zero", 32'h3F800000, 32'h00000000, 32'h7F800000, 4'h4, 4'd1);
        run("zero_zero",   32'h00000000, 32'h00000000, 32'h7FC00000, 4'h8, 4'd1);
        run("nan_op",      32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'h8, 4'd1);
        run("inf_inf",     32'h7F800000, 32'hFF800000, 32'h7FC00000, 4'h8, 4'd1);
        run("inf_num",     32'hFF800000, 32'h40000000, 32'hFF800000, 4'h0, 4'd1);
        run("num_inf",     32'h40000000, 32'hFF800000, 32'h80000000, 4'h0, 4'd1);
        run("overflow",    32'h7F000000, 32'h3E800000, 32'h7F800000, 4'h2, 4'd2);
        run("underflow",   32'h00800000, 32'h7F000000, 32'h00000000, 4'h1, 4'd2);
        run("neg_uflow",   32'h80800000, 32'h7F000000, 32'h80000000, 4'h1, 4'd2);

        // Backpressure: response held, new requests ignored
        resp_ready = 1'b0;
        issue(32'h40C00000, 32'h40000000, 32'h40400000, 4'h0, 4'd2);
        collect("bp");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", {31'd0, resp_valid}, 32'd1);
            chk("bp_hold_d", d, 32'h40400000);
            chk("bp_hold_ready", {31'd0, req_ready}, 32'd0);
            chk("bp_hold_div_s", div_s, 32'h40C00000);
            req_valid = (i % 2 == 0);
            s = 32'h3F800000;
            t = 32'h00000000;
        end
        @(negedge clk);
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        finish_hs("bp");
        chk("bp_after_d", d, 32'h40400000);
        chk("bp_after_div_s", div_s, 32'h40C00000);

        // Reset one cycle after accept aborts the request
        issue(32'h40C00000, 32'h40000000, 32'h40400000, 4'h0, 4'd2);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        void'(q.pop_front());
        chk("abort_valid", {31'd0, resp_valid}, 32'd0);
        chk("abort_d", d, 32'd0);
        chk("abort_ready", {31'd0, req_ready}, 32'd1);
        chk("abort_div_s", div_s, 32'd0);
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | resp_valid;
        end
        chk("abort_no_resp", {31'd0, seen}, 32'd0);

        run("recover", 32'h40C00000, 32'h40000000, 32'h40400000, 4'h0, 4'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
